prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//   Upstream stage of the single-cycle core. Streams a program into instruction memory
//   over a valid/ready word interface, then releases the core by asserting core_run.
//   Drives the instruction-memory write port (reset/write_enable/address/data_in/mode).
//   The core's PC/fetch path must hold while core_run=0.
// PARAMETERS
//   ADDR_W  5   instruction-memory word-address width (matches 5-bit PC)
//   DATA_W  32  instruction width
//   DEPTH   32  words in instruction memory; must satisfy DEPTH <= 2**ADDR_W
// PORTS
//   clk          in   1         single clock, all state on posedge
//   reset        in   1         asynchronous, active-high; clears all state
//   load_req     in   1         one-cycle pulse: start/restart a program load
//   s_valid      in   1         input word valid
//   s_data       in   DATA_W    instruction word, in program order from address 0
//   s_last       in   1         marks final word of program (sampled with beat)
//   s_ready      out  1         loader accepts a word this cycle
//   im_reset     out  1         instruction-memory clear pulse
//   im_we        out  1         instruction-memory write_enable
//   im_mode      out  1         1 = read (core fetch), 0 = write
//   im_addr      out  ADDR_W    write address
//   im_din       out  DATA_W    write data
//   core_run     out  1         core may fetch/execute; low freezes PC
//   load_err     out  1         sticky overflow error
//   word_count   out  ADDR_W+1  words written in current/last load
// BEHAVIOUR
//   Reset values: state=IDLE, s_ready=0, im_reset=0, im_we=0, im_mode=1, im_addr=0,
//     im_din=0, core_run=0, load_err=0, word_count=0. All outputs registered.
//   FSM states: IDLE, CLEAR, LOAD, DRAIN, RUN, ERR.
//   IDLE : s_ready=0. load_req -> CLEAR.
//   CLEAR: exactly one cycle; im_reset=1, core_run=0, load_err:=0, word_count:=0,
//          ptr:=0. -> LOAD.
//   LOAD : s_ready=1. Beat = s_valid & s_ready. Per beat, next cycle:
//          im_we=1, im_mode=0, im_addr=ptr, im_din=s_data (1-cycle pulse), ptr+1,
//          word_count+1. Back-to-back beats: one write per cycle, no bubbles.
//          No beat: im_we=0, im_mode=1.
//          Beat with s_last=1 -> DRAIN.
//          Beat at ptr==DEPTH-1 with s_last=0 -> ERR (word still written).
//   DRAIN: s_ready=0. Last write pulse occurs in this cycle. -> RUN.
//          core_run rises 2 cycles after the last beat.
//   RUN  : core_run=1, im_mode=1, im_we=0, s_ready=0. Beats ignored.
//   ERR  : load_err=1, core_run=0, s_ready=0. Holds until load_req.
//   load_req in any state except CLEAR -> CLEAR next cycle; core_run drops that cycle;
//     a beat coincident with load_req is dropped (not written).
//   load_req while in CLEAR is ignored.
//   Beat with s_last=1 at ptr==DEPTH-1 is a legal full program -> DRAIN, no error.
//   s_valid outside LOAD is ignored.
//   ptr never wraps: ERR is entered instead.
//   Async reset mid-load: immediate return to reset values; memory holds a partial
//     image; core_run stays 0 until a complete load.
// STRUCTURE
//   Shared package/header: FSM state encodings, IM_MODE_READ=1 / IM_MODE_WRITE=0
//     (also used by the core and data memory).
//   Single module, no sub-modules; FSM plus address counter plus registered write port.
// TESTING
//   1 load_req, 4 beats 0x20090005,0x200A0003,0x012A5820,0x00000008 (last on beat 4),
//     s_valid held high -> im_we pulses at addr 0..3 on consecutive cycles,
//     word_count=4, core_run=1 two cycles after beat 4.
//   2 s_valid toggled 1,0,1,0,1(last) -> writes at addr 0,1,2 only on beat cycles;
//     im_mode=1 on gap cycles; core_run asserted after 3rd write.
//   3 32 beats, last on 32nd -> writes addr 0..31, load_err=0, core_run=1.
//     33-beat stream without last by 32nd -> ERR after 32nd write; s_ready=0;
//     load_err=1; core_run=0.
//   4 In RUN, pulse load_req -> core_run=0 next cycle, im_reset pulses 1 cycle,
//     word_count=0, new 2-word load succeeds.
//   5 Assert reset after 2 of 5 beats -> all outputs at reset values asynchronously;
//     next load_req restarts at addr 0.
//   6 Beat coincident with load_req in LOAD -> that word not written; first write of
//     the new load goes to addr 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader, core fetch path and data memory:
// loader FSM encodings and the instruction-memory mode encoding.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_t;

    localparam logic IM_MODE_READ  = 1'b1;
    localparam logic IM_MODE_WRITE = 1'b0;

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready word stream carrying a program image into the loader.
interface prog_loader_if #(
    parameter int DATA_W = 32
) ();

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);

endinterface

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, then releases the core via core_run.
// Every output is a register loaded from the next-state decode.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    prog_loader_if.slave      s,
    output logic              im_reset,
    output logic              im_we,
    output logic              im_mode,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_din,
    output logic              core_run,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    loader_state_t     state, state_d;
    logic [ADDR_W-1:0] ptr;
    logic              beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // load_req pre-empts every state but CLEAR, so a coincident beat is never accepted.
    always_comb begin
        state_d = state;
        beat    = 1'b0;
        if (load_req && state != ST_CLEAR) begin
            state_d = ST_CLEAR;
        end else begin
            case (state)
                ST_IDLE:  state_d = ST_IDLE;
                ST_CLEAR: state_d = ST_LOAD;
                ST_LOAD: begin
                    if (s.s_valid && s.s_ready) begin
                        beat = 1'b1;
                        if (s.s_last) begin
                            state_d = ST_DRAIN;
                        end else if (ptr == LAST_PTR) begin
                            state_d = ST_ERR;
                        end
                    end
                end
                ST_DRAIN: state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                ST_ERR:   state_d = ST_ERR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s.s_ready  <= 1'b0;
            im_reset   <= 1'b0;
            im_we      <= 1'b0;
            im_mode    <= IM_MODE_READ;
            im_addr    <= '0;
            im_din     <= '0;
            core_run   <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            ptr        <= '0;
        end else begin
            s.s_ready <= (state_d == ST_LOAD);
            im_reset  <= (state_d == ST_CLEAR);
            core_run  <= (state_d == ST_RUN);
            im_we     <= beat;
            im_mode   <= beat ? IM_MODE_WRITE : IM_MODE_READ;

            if (state_d == ST_CLEAR) begin
                ptr        <= '0;
                word_count <= '0;
                load_err   <= 1'b0;
            end else begin
                if (beat) begin
                    im_addr    <= ptr;
                    im_din     <= s.s_data;
                    word_count <= word_count + 1'b1;
                    // The pointer saturates at the top word; overflow goes to ERR instead.
                    if (ptr != LAST_PTR) begin
                        ptr <= ptr + 1'b1;
                    end
                end
                if (state_d == ST_ERR) begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load, gaps, full/overflow, reload, async reset, abort.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic        load_req;
    logic        im_reset, im_we, im_mode, core_run, load_err;
    logic [4:0]  im_addr;
    logic [31:0] im_din;
    logic [5:0]  word_count;
    int          total = 0;
    int          bad   = 0;

    prog_loader_if #(.DATA_W(32)) sif ();

    prog_loader #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .s          (sif.slave),
        .im_reset   (im_reset),
        .im_we      (im_we),
        .im_mode    (im_mode),
        .im_addr    (im_addr),
        .im_din     (im_din),
        .core_run   (core_run),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control snapshot: {s_ready, im_reset, im_we, im_mode, core_run, load_err, word_count}
    function automatic logic [11:0] obs();
        return {sif.s_ready, im_reset, im_we, im_mode, core_run, load_err, word_count};
    endfunction

    function automatic logic [11:0] ctl(input logic sr, input logic ir, input logic we,
                                        input logic md, input logic cr, input logic le,
                                        input int wc);
        return {sr, ir, we, md, cr, le, 6'(wc)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = last;
    endtask

    task automatic idle_bus();
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
    endtask

    task automatic start_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_req = 1'b0;
        idle_bus();
        #2;
        total++;
        if (obs() !== ctl(0,0,0,1,0,0,0)) begin
            bad++; $display("FAIL reset_ctl got=%h exp=%h", obs(), ctl(0,0,0,1,0,0,0));
        end
        total++;
        if ({im_addr, im_din} !== 37'd0) begin
            bad++; $display("FAIL reset_wr got=%h exp=0", {im_addr, im_din});
        end
        step();
        reset = 1'b0;
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,0,0,0)) begin
            bad++; $display("FAIL idle_ctl got=%h exp=%h", obs(), ctl(0,0,0,1,0,0,0));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4] = '{32'h20090005, 32'h200A0003, 32'h012A5820, 32'h00000008};
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        total++;
        if (obs() !== ctl(0,1,0,1,0,0,0)) begin
            bad++; $display("FAIL b2b_clear got=%h exp=%h", obs(), ctl(0,1,0,1,0,0,0));
        end
        step();
        total++;
        if (obs() !== ctl(1,0,0,1,0,0,0)) begin
            bad++; $display("FAIL b2b_load got=%h exp=%h", obs(), ctl(1,0,0,1,0,0,0));
        end
        for (int i = 0; i < 4; i++) begin
            beat(prog[i], i == 3);
            step();
            total++;
            if (obs() !== ctl(i < 3, 0, 1, 0, 0, 0, i + 1) || im_addr !== 5'(i) || im_din !== prog[i]) begin
                bad++; $display("FAIL b2b_beat%0d got=%h/%0d/%h exp=%h/%0d/%h", i, obs(), im_addr,
                                im_din, ctl(i < 3, 0, 1, 0, 0, 0, i + 1), i, prog[i]);
            end
        end
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,1,0,4)) begin
            bad++; $display("FAIL b2b_run got=%h exp=%h", obs(), ctl(0,0,0,1,1,0,4));
        end
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,1,0,4)) begin
            bad++; $display("FAIL b2b_run_ignore got=%h exp=%h", obs(), ctl(0,0,0,1,1,0,4));
        end
        idle_bus();
    endtask

    task automatic test_gaps();
        logic [31:0] prog [3] = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
        start_load();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) beat(prog[i / 2], i == 4);
            else idle_bus();
            step();
            total++;
            if (i % 2 == 0) begin
                if (obs() !== ctl(i < 4, 0, 1, 0, 0, 0, i / 2 + 1) || im_addr !== 5'(i / 2)
                    || im_din !== prog[i / 2]) begin
                    bad++; $display("FAIL gap_beat%0d got=%h/%0d/%h exp=%h/%0d/%h", i, obs(), im_addr,
                                    im_din, ctl(i < 4, 0, 1, 0, 0, 0, i / 2 + 1), i / 2, prog[i / 2]);
                end
            end else if (obs() !== ctl(1, 0, 0, 1, 0, 0, (i + 1) / 2)) begin
                bad++; $display("FAIL gap_idle%0d got=%h exp=%h", i, obs(), ctl(1, 0, 0, 1, 0, 0, (i + 1) / 2));
            end
        end
        idle_bus();
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,1,0,3)) begin
            bad++; $display("FAIL gap_run got=%h exp=%h", obs(), ctl(0,0,0,1,1,0,3));
        end
    endtask

    task automatic test_full_and_overflow();
        start_load();
        for (int i = 0; i < 32; i++) begin
            beat(32'h10000000 + 32'(i), i == 31);
            step();
            total++;
            if (obs() !== ctl(i < 31, 0, 1, 0, 0, 0, i + 1) || im_addr !== 5'(i)
                || im_din !== 32'h10000000 + 32'(i)) begin
                bad++; $display("FAIL full_beat%0d got=%h/%0d/%h exp=%h/%0d", i, obs(), im_addr, im_din,
                                ctl(i < 31, 0, 1, 0, 0, 0, i + 1), i);
            end
        end
        idle_bus();
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,1,0,32)) begin
            bad++; $display("FAIL full_run got=%h exp=%h", obs(), ctl(0,0,0,1,1,0,32));
        end
        start_load();
        for (int i = 0; i < 32; i++) begin
            beat(32'h20000000 + 32'(i), 1'b0);
            step();
            total++;
            if (obs() !== ctl(i < 31, 0, 1, 0, 0, i == 31, i + 1) || im_addr !== 5'(i)) begin
                bad++; $display("FAIL ovf_beat%0d got=%h/%0d exp=%h/%0d", i, obs(), im_addr,
                                ctl(i < 31, 0, 1, 0, 0, i == 31, i + 1), i);
            end
        end
        beat(32'h2000_0020, 1'b0);
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,0,1,32)) begin
            bad++; $display("FAIL ovf_err got=%h exp=%h", obs(), ctl(0,0,0,1,0,1,32));
        end
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,0,1,32)) begin
            bad++; $display("FAIL ovf_hold got=%h exp=%h", obs(), ctl(0,0,0,1,0,1,32));
        end
        idle_bus();
    endtask

    task automatic test_reload_from_run();
        start_load();
        beat(32'h11111111, 1'b1);
        step();
        idle_bus();
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,1,0,1)) begin
            bad++; $display("FAIL rl_run got=%h exp=%h", obs(), ctl(0,0,0,1,1,0,1));
        end
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        total++;
        if (obs() !== ctl(0,1,0,1,0,0,0)) begin
            bad++; $display("FAIL rl_clear got=%h exp=%h", obs(), ctl(0,1,0,1,0,0,0));
        end
        step();
        total++;
        if (obs() !== ctl(1,0,0,1,0,0,0)) begin
            bad++; $display("FAIL rl_load got=%h exp=%h", obs(), ctl(1,0,0,1,0,0,0));
        end
        beat(32'h22222222, 1'b0);
        step();
        beat(32'h33333333, 1'b1);
        step();
        total++;
        if (obs() !== ctl(0,0,1,0,0,0,2) || im_addr !== 5'd1 || im_din !== 32'h33333333) begin
            bad++; $display("FAIL rl_beat2 got=%h/%0d/%h exp=%h/1/33333333", obs(), im_addr, im_din,
                            ctl(0,0,1,0,0,0,2));
        end
        idle_bus();
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,1,0,2)) begin
            bad++; $display("FAIL rl_run2 got=%h exp=%h", obs(), ctl(0,0,0,1,1,0,2));
        end
    endtask

    task automatic test_async_reset();
        start_load();
        beat(32'h44444444, 1'b0);
        step();
        beat(32'h55555555, 1'b0);
        step();
        total++;
        if (obs() !== ctl(1,0,1,0,0,0,2) || im_addr !== 5'd1) begin
            bad++; $display("FAIL ar_pre got=%h/%0d exp=%h/1", obs(), im_addr, ctl(1,0,1,0,0,0,2));
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs() !== ctl(0,0,0,1,0,0,0) || {im_addr, im_din} !== 37'd0) begin
            bad++; $display("FAIL ar_async got=%h/%h exp=%h/0", obs(), {im_addr, im_din}, ctl(0,0,0,1,0,0,0));
        end
        #1;
        reset = 1'b0;
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,0,0,0)) begin
            bad++; $display("FAIL ar_idle got=%h exp=%h", obs(), ctl(0,0,0,1,0,0,0));
        end
        idle_bus();
        start_load();
        beat(32'h66666666, 1'b1);
        step();
        total++;
        if (obs() !== ctl(0,0,1,0,0,0,1) || im_addr !== 5'd0 || im_din !== 32'h66666666) begin
            bad++; $display("FAIL ar_restart got=%h/%0d/%h exp=%h/0/66666666", obs(), im_addr, im_din,
                            ctl(0,0,1,0,0,0,1));
        end
        idle_bus();
        step();
    endtask

    task automatic test_abort_beat();
        start_load();
        beat(32'h77777777, 1'b0);
        step();
        beat(32'h88888888, 1'b0);
        step();
        beat(32'hDEADBEEF, 1'b0);
        load_req = 1'b1;
        step();
        total++;
        if (obs() !== ctl(0,1,0,1,0,0,0)) begin
            bad++; $display("FAIL ab_drop got=%h exp=%h", obs(), ctl(0,1,0,1,0,0,0));
        end
        step();
        total++;
        if (obs() !== ctl(1,0,0,1,0,0,0)) begin
            bad++; $display("FAIL ab_clear_ignore got=%h exp=%h", obs(), ctl(1,0,0,1,0,0,0));
        end
        load_req = 1'b0;
        beat(32'h99999999, 1'b1);
        step();
        total++;
        if (obs() !== ctl(0,0,1,0,0,0,1) || im_addr !== 5'd0 || im_din !== 32'h99999999) begin
            bad++; $display("FAIL ab_first got=%h/%0d/%h exp=%h/0/99999999", obs(), im_addr, im_din,
                            ctl(0,0,1,0,0,0,1));
        end
        idle_bus();
        step();
        total++;
        if (obs() !== ctl(0,0,0,1,1,0,1)) begin
            bad++; $display("FAIL ab_run got=%h exp=%h", obs(), ctl(0,0,0,1,1,0,1));
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_full_and_overflow();
        test_reload_from_run();
        test_async_reset();
        test_abort_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
